// File: rtl/posit_mult_stream_es3_pkg.sv
// Shared types and constants for the ES=3 posit multiplier and its streaming wrapper.
package posit_defines_es3;

   localparam int unsigned NBITS        = 32;
   localparam int unsigned MULT_LATENCY = 4;

   // One completed product as delivered by the multiplier.
   typedef struct packed {
      logic [NBITS-1:0] result;
      logic             inf;
      logic             zero;
   } mult_result;

   // Wrapper control state: FLUSH drains stale multiplier output after reset.
   typedef enum logic {
      FLUSH = 1'b0,
      RUN   = 1'b1
   } stream_state_e;

endpackage

// File: rtl/posit_result_fifo.sv
// In-order circular buffer of multiplier products with occupancy count.
module posit_result_fifo
   import posit_defines_es3::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         push,
   input  mult_result                   wdata,
   input  logic                         pop,
   output mult_result                   rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   mult_result    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Pointer and occupancy tracking; pointers wrap at the power-of-two depth.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage array; contents are only observable while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Head entry, forced to zero when empty so stale data never leaks out.
   assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/posit_mult_stream_es3.sv
// Valid/ready streaming wrapper around the fixed-latency ES=3 posit multiplier.
module posit_mult_stream_es3 #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned NBITS = posit_defines_es3::NBITS
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NBITS-1:0]             in_a,
   input  logic [NBITS-1:0]             in_b,
   output logic                         mul_start,
   output logic [NBITS-1:0]             mul_in1,
   output logic [NBITS-1:0]             mul_in2,
   input  logic                         mul_done,
   input  logic [NBITS-1:0]             mul_result,
   input  logic                         mul_inf,
   input  logic                         mul_zero,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NBITS-1:0]             out_result,
   output logic                         out_inf,
   output logic                         out_zero,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         error
);

   import posit_defines_es3::*;

   localparam int unsigned LW = $clog2(DEPTH+1);
   localparam int unsigned FW = $clog2(MULT_LATENCY+1);

   stream_state_e state;
   logic [FW-1:0] flush_cnt;
   logic [LW-1:0] inflight;
   logic [LW-1:0] count;
   logic [LW:0]   reserved;
   logic          run;
   logic          accept;
   logic          done_bad;
   logic          done_ok;
   logic          pop;
   mult_result    wr_entry;
   mult_result    head;

   // Issue side: ready depends only on registered state, never on out_ready.
   assign run       = (state == RUN);
   assign reserved  = {1'b0, inflight} + {1'b0, count};
   assign level     = LW'(reserved);
   assign in_ready  = run && (32'(reserved) < DEPTH);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept;
   assign mul_in1   = accept ? in_a : '0;
   assign mul_in2   = accept ? in_b : '0;

   // A done with nothing in flight or no room is a protocol violation and is dropped.
   assign done_bad  = run && mul_done && ((inflight == '0) || (count == LW'(DEPTH)));
   assign done_ok   = run && mul_done && !done_bad;

   // Consumer side.
   assign out_valid  = (count != '0);
   assign pop        = out_valid && out_ready;
   assign out_result = head.result;
   assign out_inf    = head.inf;
   assign out_zero   = head.zero;

   assign wr_entry = '{result: mul_result, inf: mul_inf, zero: mul_zero};

   // Flush/run control: wait out the multiplier pipeline before trusting done.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FLUSH;
         flush_cnt <= FW'(MULT_LATENCY);
      end else if (state == FLUSH) begin
         flush_cnt <= flush_cnt - FW'(1);
         if (flush_cnt == FW'(1)) state <= RUN;
      end
   end

   // In-flight slot count and sticky protocol error.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= '0;
         error    <= 1'b0;
      end else begin
         inflight <= inflight + LW'(accept) - LW'(done_ok);
         if (done_bad) error <= 1'b1;
      end
   end

   posit_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (done_ok),
      .wdata   (wr_entry),
      .pop     (pop),
      .rdata   (head),
      .count   (count)
   );

endmodule
